// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Drives the fetch address to instruction memory under a valid/ready handshake.
// The next PC is chosen with this priority: trap, redirect, return-stack pop,
// sequential. A small circular return-address stack predicts return targets.
// A redirect to a misaligned target is sent to the trap handler instead, and
// misalign_err pulses for one cycle.
module pc_gen #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          INSTR_BYTES  = 4,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_base,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign_err,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned LSB = $clog2(INSTR_BYTES);
  localparam int unsigned PW  = $clog2(RAS_DEPTH);
  localparam int unsigned CW  = PW + 1;

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));
  localparam logic [CW-1:0]   RAS_MAX    = CW'(RAS_DEPTH);

  localparam logic [0:0] S_BOOT  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  logic [0:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [PW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];

  logic            w_fetch;
  logic            w_fire;
  logic            w_override;
  logic            w_misaligned;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_top_idx;
  logic [XLEN-1:0] w_ras_top;
  logic [XLEN-1:0] w_trap_pc;
  logic [XLEN-1:0] w_next_seq;
  logic [XLEN-1:0] w_pc_d;

  assign w_fetch      = (r_state == S_FETCH);
  assign w_fire       = w_fetch & fetch_ready & ~stall;
  assign w_override   = w_fetch & (trap_valid | redirect_valid);
  assign w_misaligned = |redirect_target[LSB-1:0];
  assign w_trap_pc    = trap_base & ALIGN_MASK;
  assign w_next_seq   = r_pc + STEP;

  // Top of stack sits one slot below the write pointer.
  assign w_top_idx = r_wptr - PW'(1);
  assign w_ras_top = r_ras[w_top_idx];

  assign w_push = w_fire & call_push & ~w_override;
  assign w_pop  = w_fire & ret_pop & ~ras_empty & ~w_override;

  assign fetch_valid  = w_fetch;
  assign current_pc   = r_pc;
  assign next_pc      = w_next_seq;
  assign misalign_err = r_misalign;
  assign ras_empty    = (r_count == '0);
  assign ras_full     = (r_count == RAS_MAX);

  // Next-PC selection by priority.
  always_comb begin
    w_pc_d = r_pc;
    if (w_fetch) begin
      if (trap_valid)
        w_pc_d = w_trap_pc;
      else if (redirect_valid)
        w_pc_d = w_misaligned ? w_trap_pc : redirect_target;
      else if (w_pop)
        w_pc_d = w_ras_top;
      else if (w_fire)
        w_pc_d = w_next_seq;
    end
  end

  // State, PC, misalign pulse and stack bookkeeping.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= S_FETCH;
      r_pc       <= w_pc_d;
      r_misalign <= w_fetch & ~trap_valid & redirect_valid & w_misaligned;
      // A push and pop on the same fire replaces the top in place, so the
      // pointer and count only move when exactly one of them happens.
      if (w_push && !w_pop) begin
        r_wptr <= r_wptr + PW'(1);
        if (r_count != RAS_MAX)
          r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_wptr  <= w_top_idx;
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Stack storage; a push onto a full stack wraps onto the oldest entry.
  always_ff @(posedge sys_clk) begin
    if (w_push && w_pop)
      r_ras[w_top_idx] <= w_next_seq;
    else if (w_push)
      r_ras[r_wptr] <= w_next_seq;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, handshake hold, trap/redirect priority,
// misaligned redirect, return stack overflow/underflow, address wrap.
module tb_pc_gen;

  logic        sys_clk;
  logic        sys_rst;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_base;
  logic        call_push;
  logic        ret_pop;
  logic [31:0] current_pc;
  logic [31:0] next_pc;
  logic        misalign_err;
  logic        ras_empty;
  logic        ras_full;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .XLEN(32),
    .RESET_VECTOR(32'h0),
    .INSTR_BYTES(4),
    .RAS_DEPTH(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .stall(stall),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid(trap_valid),
    .trap_base(trap_base),
    .call_push(call_push),
    .ret_pop(ret_pop),
    .current_pc(current_pc),
    .next_pc(next_pc),
    .misalign_err(misalign_err),
    .ras_empty(ras_empty),
    .ras_full(ras_full)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    logic [31:0] pop_exp [5];
    pop_exp[0] = 32'h44; pop_exp[1] = 32'h34; pop_exp[2] = 32'h24;
    pop_exp[3] = 32'h14; pop_exp[4] = 32'h18;

    sys_rst = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; trap_base = '0;
    call_push = 1'b0; ret_pop = 1'b0;

    // Reset state
    step(); step();
    check("rst_pc", current_pc, 32'h0);
    check("rst_fv", fetch_valid, 1'b0);
    check("rst_mis", misalign_err, 1'b0);
    check("rst_empty", ras_empty, 1'b1);
    check("rst_full", ras_full, 1'b0);

    // Release: BOOT for one cycle, then sequential fetch
    sys_rst = 1'b1;
    check("boot_fv", fetch_valid, 1'b0);
    step();
    check("fetch0_fv", fetch_valid, 1'b1);
    check("fetch0_pc", current_pc, 32'h0);
    step(); check("fetch1_pc", current_pc, 32'h4);
    step(); check("fetch2_pc", current_pc, 32'h8);
    check("fetch2_npc", next_pc, 32'hC);

    // Asynchronous reset mid-run
    #2 sys_rst = 1'b0;
    #1;
    check("async_pc", current_pc, 32'h0);
    check("async_fv", fetch_valid, 1'b0);
    step(); step();
    sys_rst = 1'b1;
    step(); step(); step(); step(); step();
    check("seq_pc10", current_pc, 32'h10);

    // Memory not ready: hold, redirect overrides on the second cycle
    fetch_ready = 1'b0;
    step(); check("hold1_pc", current_pc, 32'h10);
    redirect_valid = 1'b1; redirect_target = 32'h200;
    step(); check("redir_nr_pc", current_pc, 32'h200);
    redirect_valid = 1'b0;
    step(); check("hold3_pc", current_pc, 32'h200);
    fetch_ready = 1'b1;
    step(); check("resume_pc", current_pc, 32'h204);
    check("resume_npc", next_pc, 32'h208);

    // Trap beats redirect, ignores stall, aligns base
    trap_valid = 1'b1; trap_base = 32'h1003;
    redirect_valid = 1'b1; redirect_target = 32'h300; stall = 1'b1;
    step(); check("trap_pc", current_pc, 32'h1000);
    check("trap_empty", ras_empty, 1'b1);
    check("trap_mis", misalign_err, 1'b0);
    trap_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;

    // Misaligned redirect goes to the aligned trap base, one-cycle pulse
    redirect_valid = 1'b1; redirect_target = 32'h302;
    step(); check("mis_pc", current_pc, 32'h1000);
    check("mis_pulse", misalign_err, 1'b1);
    redirect_valid = 1'b0;
    step(); check("mis_after_pc", current_pc, 32'h1004);
    check("mis_clear", misalign_err, 1'b0);

    // Five calls from 0x0, 0x10 .. 0x40
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step(); check("goto0_pc", current_pc, 32'h0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      call_push = 1'b1;
      step(); check("call_pc", current_pc, 32'(16 * i + 4));
      call_push = 1'b0;
      check("call_empty", ras_empty, 1'b0);
      check("call_full", ras_full, (i >= 3) ? 1'b1 : 1'b0);
      if (i < 4) begin
        redirect_valid = 1'b1; redirect_target = 32'(16 * (i + 1));
        step(); check("call_site_pc", current_pc, 32'(16 * (i + 1)));
        redirect_valid = 1'b0;
      end
    end

    // Stalled return: no pop, no PC change
    stall = 1'b1; ret_pop = 1'b1;
    step(); check("stall_pc", current_pc, 32'h44);
    check("stall_full", ras_full, 1'b1);
    stall = 1'b0;

    // Five returns: four predicted, fifth on empty goes sequential
    for (int j = 0; j < 5; j++) begin
      step(); check("ret_pc", current_pc, pop_exp[j]);
      check("ret_empty", ras_empty, (j >= 3) ? 1'b1 : 1'b0);
      check("ret_full", ras_full, 1'b0);
    end
    ret_pop = 1'b0;

    // Push 0x80, then wrap from 0xFFFF_FFFC
    redirect_valid = 1'b1; redirect_target = 32'h7C;
    step(); check("goto7c_pc", current_pc, 32'h7C);
    redirect_valid = 1'b0; call_push = 1'b1;
    step(); check("push80_pc", current_pc, 32'h80);
    call_push = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(); check("top_pc", current_pc, 32'hFFFF_FFFC);
    check("wrap_npc", next_pc, 32'h0);
    redirect_valid = 1'b0;
    step(); check("wrap_pc", current_pc, 32'h0);

    // Simultaneous push and pop: target old top, top replaced by 0x4
    call_push = 1'b1; ret_pop = 1'b1;
    step(); check("pushpop_pc", current_pc, 32'h80);
    check("pushpop_empty", ras_empty, 1'b0);
    call_push = 1'b0;
    step(); check("newtop_pc", current_pc, 32'h4);
    check("newtop_empty", ras_empty, 1'b1);
    ret_pop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-width PC register in the fetch stage.
- Produces the fetch address under a valid/ready handshake with instruction memory.
- Selects the next PC by priority: trap, then redirect, then return-stack pop, then sequential.
- Holds a small circular return-address stack (RAS) and flags misaligned targets.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 0, PC loaded at reset (XLEN bits).
- INSTR_BYTES, 4, sequential increment; power of two, at least 2.
- RAS_DEPTH, 4, return-stack entries; power of two, at least 2.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst  in  1  asynchronous active-low reset.
- stall  in  1  blocks sequential and RAS advance; does not block trap or redirect.
- fetch_ready  in  1  instruction memory accepts current_pc.
- fetch_valid  out  1  current_pc is a valid fetch request.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  XLEN  branch/jump destination.
- trap_valid  in  1  take trap.
- trap_base  in  XLEN  trap handler address; low log2(INSTR_BYTES) bits ignored (treated as 0).
- call_push  in  1  fetched instruction is a call; push return address.
- ret_pop  in  1  fetched instruction is a return; predict RAS top.
- current_pc  out  XLEN  address being fetched.
- next_pc  out  XLEN  current_pc + INSTR_BYTES, combinational, modulo 2^XLEN.
- misalign_err  out  1  one-cycle pulse: misaligned redirect seen.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count is RAS_DEPTH.

Behaviour:
- Reset (sys_rst low, async):
  - state = BOOT, current_pc = RESET_VECTOR, fetch_valid = 0, misalign_err = 0.
  - RAS count = 0 and pointer = 0; entries are don't-care.
  - Reset mid-operation discards any pending redirect, trap or fetch.
- States:
  - BOOT: fetch_valid = 0. Goes to FETCH on the first clock after reset release. No PC update in BOOT, including trap or redirect.
  - FETCH: fetch_valid = 1 continuously. Stays in FETCH.
- fire = fetch_valid & fetch_ready & ~stall.
- PC update priority, evaluated each cycle in FETCH:
  1. trap_valid: current_pc = trap_base with low bits cleared. Taken regardless of fire or stall. RAS unchanged.
  2. redirect_valid with target aligned: current_pc = redirect_target, regardless of fire or stall. RAS unchanged.
  3. redirect_valid with target misaligned (low log2(INSTR_BYTES) bits nonzero): current_pc = aligned trap_base; misalign_err = 1 for exactly the next cycle.
  4. fire & ret_pop & ~ras_empty: current_pc = RAS top; pop.
  5. fire with ret_pop on an empty RAS, or fire with no pop: current_pc = next_pc.
  6. Otherwise hold current_pc (memory not ready, or stall).
- Handshake: current_pc stays stable while fetch_valid & ~fetch_ready, except when trap or redirect overrides it (request flush; the new address is presented the next cycle).
- RAS:
  - Push on fire & call_push, only when neither trap nor redirect is taken that cycle. Pushed value = next_pc.
  - Full push: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop on empty: no change; count stays 0.
  - Push and pop on the same fire: target = old top; old top is replaced by the new return address; count unchanged.
- Arithmetic: all adds wrap modulo 2^XLEN. Example: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Latency: one cycle from input sample to the new current_pc. next_pc follows current_pc combinationally.

Test Plan:
- Reset release, fetch_ready = 1, no stall, defaults → first cycle fetch_valid = 0 with PC 0x0; then PCs 0x0, 0x4, 0x8 with fetch_valid = 1. Assert sys_rst mid-run → current_pc = 0x0 immediately (async), fetch_valid = 0.
- fetch_ready = 0 for 3 cycles at PC 0x10, then redirect_valid to 0x200 on cycle 2 → PC holds 0x10, then 0x200, then 0x204 once fetch_ready = 1.
- trap_valid and redirect_valid (0x300) together, trap_base = 0x1003, stall = 1 → PC = 0x1000; RAS count unchanged.
- redirect_target 0x302 → PC = aligned trap_base; misalign_err high exactly one cycle.
- Five calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40, then five returns → ras_full after the 4th call; pops return 0x44, 0x34, 0x24, 0x14; 5th pop finds ras_empty and goes sequential.
- PC 0xFFFF_FFFC, fire → PC 0x0; simultaneous call_push + ret_pop with top 0x80 → PC 0x80, new top = 0x4, count unchanged.
